// File: rtl/fuzz_equiv_sequencer_if.sv
// Bundle between the equivalence sequencer and its controller: run control,
// shared stimulus, both DUT output buses and the result registers.
interface fuzz_equiv_sequencer_if #(
  parameter int STIM_W = 29,
  parameter int Y_W    = 284,
  parameter int CNT_W  = 16
);
  // start and abort are single-cycle qualifiers sampled on posedge; the
  // sequencer has no ready: start is accepted only while done or idle (busy=0)
  // and abort only while busy=1, so a controller may hold either for one cycle.
  logic              start;
  logic              abort;
  logic [31:0]       seed;
  logic [STIM_W-1:0] stim;
  logic [Y_W-1:0]    y_a;
  logic [Y_W-1:0]    y_b;
  logic              busy;
  logic              done;
  logic              pass;
  logic              aborted;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  mismatch_count;
  logic [CNT_W-1:0]  first_fail_cycle;
  logic [Y_W-1:0]    fail_diff;
  logic [1:0]        fsm_state;

  modport master (
    output start, abort, seed, y_a, y_b,
    input  stim, busy, done, pass, aborted, cycle_cnt, mismatch_count,
           first_fail_cycle, fail_diff, fsm_state
  );

  modport slave (
    input  start, abort, seed, y_a, y_b,
    output stim, busy, done, pass, aborted, cycle_cnt, mismatch_count,
           first_fail_cycle, fail_diff, fsm_state
  );
endinterface

// File: rtl/fuzz_equiv_sequencer.sv
// Drives LFSR stimulus into two DUTs, compares their y buses every compare
// cycle and records pass/fail, first failing cycle, its XOR diff and a count.
module fuzz_equiv_sequencer #(
  parameter int STIM_W       = 29,
  parameter int Y_W          = 284,
  parameter int NUM_VECTORS  = 1024,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  fuzz_equiv_sequencer_if.slave bus
);

  localparam logic [31:0]      LFSR_MASK  = 32'h8020_0003;
  localparam logic [CNT_W-1:0] LAST_RUN   = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(NUM_VECTORS + DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [31:0]       lfsr;
  logic [31:0]       lfsr_next;
  logic [31:0]       seed_fixed;
  logic [STIM_W-1:0] stim;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  mismatch_count;
  logic [CNT_W-1:0]  first_fail_cycle;
  logic [Y_W-1:0]    fail_diff;
  logic              mismatch;
  logic              last_run;
  logic              last_drain;

  // Galois right shift: the bit falling out of lfsr[0] folds the tap mask back in.
  assign lfsr_next  = (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 32'h0);
  assign seed_fixed = (bus.seed == 32'h0) ? 32'h1 : bus.seed;
  assign mismatch   = (bus.y_a != bus.y_b);
  assign last_run   = (state == S_RUN)   && (cycle_cnt == LAST_RUN);
  assign last_drain = (state == S_DRAIN) && (cycle_cnt == LAST_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      lfsr             <= 32'h1;
      stim             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      aborted          <= 1'b0;
      cycle_cnt        <= '0;
      mismatch_count   <= '0;
      first_fail_cycle <= '1;
      fail_diff        <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state            <= S_RUN;
            lfsr             <= seed_fixed;
            stim             <= seed_fixed[STIM_W-1:0];
            busy             <= 1'b1;
            done             <= 1'b0;
            aborted          <= 1'b0;
            cycle_cnt        <= '0;
            mismatch_count   <= '0;
            first_fail_cycle <= '1;
            fail_diff        <= '0;
          end
        end
        S_RUN, S_DRAIN: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          if (mismatch) begin
            if (mismatch_count != '1) begin
              mismatch_count <= mismatch_count + 1'b1;
            end
            // A zero count means this is the first failing cycle of the run.
            if (mismatch_count == '0) begin
              first_fail_cycle <= cycle_cnt;
              fail_diff        <= bus.y_a ^ bus.y_b;
            end
          end
          // The stimulus freezes on the last RUN edge and on an abort edge.
          if ((state == S_RUN) && !last_run && !bus.abort) begin
            lfsr <= lfsr_next;
            stim <= lfsr_next[STIM_W-1:0];
          end
          if (bus.abort) begin
            state   <= S_DONE;
            aborted <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (last_run) begin
            if (DRAIN_CYCLES == 0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end else if (last_drain) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.stim             = stim;
  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.aborted          = aborted;
  assign bus.cycle_cnt        = cycle_cnt;
  assign bus.mismatch_count   = mismatch_count;
  assign bus.first_fail_cycle = first_fail_cycle;
  assign bus.fail_diff        = fail_diff;
  assign bus.fsm_state        = state;
  assign bus.pass = (state == S_DONE) && (mismatch_count == '0) && !aborted;

endmodule

// File: tb/tb_fuzz_equiv_sequencer.sv
// Directed bench: table of runs on a 16-vector instance plus hand sequences
// for seed zero, mid-run reset and counter saturation on a 4-bit instance.
module tb_fuzz_equiv_sequencer;

  localparam int STIM_W = 29;
  localparam int Y_W    = 284;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fuzz_equiv_sequencer_if #(.STIM_W(STIM_W), .Y_W(Y_W), .CNT_W(16)) bus_a ();
  fuzz_equiv_sequencer_if #(.STIM_W(STIM_W), .Y_W(Y_W), .CNT_W(4))  bus_b ();

  fuzz_equiv_sequencer #(
    .STIM_W(STIM_W), .Y_W(Y_W), .NUM_VECTORS(16), .DRAIN_CYCLES(4), .CNT_W(16)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  fuzz_equiv_sequencer #(
    .STIM_W(STIM_W), .Y_W(Y_W), .NUM_VECTORS(16), .DRAIN_CYCLES(0), .CNT_W(4)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Stand-in DUTs: y_a is a function of stim, y_b is y_a with injected flips.
  logic [10*STIM_W-1:0] rep_a;
  logic [10*STIM_W-1:0] rep_b;
  logic [Y_W-1:0]       flip_a;
  logic [Y_W-1:0]       flip_b;
  assign rep_a     = {10{bus_a.stim}};
  assign rep_b     = {10{bus_b.stim}};
  assign bus_a.y_a = rep_a[Y_W-1:0] ^ {Y_W{1'b1}};
  assign bus_a.y_b = bus_a.y_a ^ flip_a;
  assign bus_b.y_a = rep_b[Y_W-1:0];
  assign bus_b.y_b = bus_b.y_a ^ flip_b;

  typedef struct {
    logic [31:0] seed;
    int          flip_cyc;
    int          flip_bit;
    int          abort_cyc;
    int          start_cyc;
    int          exp_compares;
    logic        exp_pass;
    logic [15:0] exp_mm;
    logic [15:0] exp_ffc;
    logic        exp_aborted;
  } vec_t;

  vec_t vecs[8];

  // scoreboard
  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [STIM_W-1:0] model_stim(input logic [31:0] seed, input int n);
    logic [31:0] l;
    l = (seed == 32'h0) ? 32'h1 : seed;
    for (int i = 0; i < n; i++) l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    return l[STIM_W-1:0];
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_state"}, bus_a.fsm_state, 2'd0);
    chk({tag, "_stim"}, bus_a.stim, 0);
    chk({tag, "_cycle_cnt"}, bus_a.cycle_cnt, 0);
    chk({tag, "_mismatch"}, bus_a.mismatch_count, 0);
    chk({tag, "_first_fail"}, bus_a.first_fail_cycle, 16'hFFFF);
    chk({tag, "_fail_diff"}, bus_a.fail_diff, 0);
    chk({tag, "_busy"}, bus_a.busy, 1'b0);
    chk({tag, "_done"}, bus_a.done, 1'b0);
    chk({tag, "_pass"}, bus_a.pass, 1'b0);
    chk({tag, "_aborted"}, bus_a.aborted, 1'b0);
  endtask

  // driver: one run on dut_a, stepping and checking at negedge
  task automatic run_vec(input vec_t v, input int idx);
    int k;
    int last_vec;
    logic [Y_W-1:0] ediff;
    bus_a.seed  = v.seed;
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    chk($sformatf("v%0d_first_stim", idx), bus_a.stim, model_stim(v.seed, 0));
    k = 0;
    while (bus_a.done !== 1'b1 && k < 200) begin
      flip_a = '0;
      if (k == v.flip_cyc) flip_a[v.flip_bit] = 1'b1;
      bus_a.abort = (k == v.abort_cyc);
      bus_a.start = (k == v.start_cyc);
      @(negedge clk);
      k++;
    end
    flip_a      = '0;
    bus_a.abort = 1'b0;
    bus_a.start = 1'b0;
    ediff = '0;
    if (v.flip_cyc >= 0 && v.flip_cyc < v.exp_compares) ediff[v.flip_bit] = 1'b1;
    last_vec = (v.exp_compares - 1 < 15) ? v.exp_compares - 1 : 15;
    chk($sformatf("v%0d_compares", idx), k, v.exp_compares);
    chk($sformatf("v%0d_cycle_cnt", idx), bus_a.cycle_cnt, v.exp_compares);
    chk($sformatf("v%0d_pass", idx), bus_a.pass, v.exp_pass);
    chk($sformatf("v%0d_mismatch", idx), bus_a.mismatch_count, v.exp_mm);
    chk($sformatf("v%0d_first_fail", idx), bus_a.first_fail_cycle, v.exp_ffc);
    chk($sformatf("v%0d_fail_diff", idx), bus_a.fail_diff, ediff);
    chk($sformatf("v%0d_aborted", idx), bus_a.aborted, v.exp_aborted);
    chk($sformatf("v%0d_done_busy", idx), {bus_a.done, bus_a.busy}, 2'b10);
    chk($sformatf("v%0d_frozen_stim", idx), bus_a.stim, model_stim(v.seed, last_vec));
  endtask

  initial begin
    int k;
    total = 0;
    bad   = 0;
    vecs[0] = '{32'h0000_ACE1, -1,   0, -1, -1, 20, 1'b1, 16'd0, 16'hFFFF, 1'b0};
    vecs[1] = '{32'h0000_ACE1,  7,   5, -1, -1, 20, 1'b0, 16'd1, 16'd7,    1'b0};
    vecs[2] = '{32'h1234_5678, 19, 100, -1, -1, 20, 1'b0, 16'd1, 16'd19,   1'b0};
    vecs[3] = '{32'hDEAD_BEEF,  0, 283, -1, -1, 20, 1'b0, 16'd1, 16'd0,    1'b0};
    vecs[4] = '{32'h0000_ACE1, -1,   0,  5,  3,  6, 1'b0, 16'd0, 16'hFFFF, 1'b1};
    vecs[5] = '{32'h0BAD_F00D, -1,   0, 15, -1, 16, 1'b0, 16'd0, 16'hFFFF, 1'b1};
    vecs[6] = '{32'hCAFE_0001, -1,   0, 17, -1, 18, 1'b0, 16'd0, 16'hFFFF, 1'b1};
    vecs[7] = '{32'h0000_0077,  2,  31,  2, -1,  3, 1'b0, 16'd1, 16'd2,    1'b1};

    rst_n = 1'b1;
    flip_a = '0;
    flip_b = '0;
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.seed = 32'h0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.seed = 32'h0;
    #3 rst_n = 1'b0;
    @(negedge clk);
    reset_checks("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // seed zero behaves as seed 1 and follows the Galois sequence
    bus_a.seed  = 32'h0;
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    chk("seed0_stim0", bus_a.stim, 29'h1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("seed0_stim%0d", i), bus_a.stim, model_stim(32'h0, i));
      if (i == 1) chk("seed0_stim1_literal", bus_a.stim, 29'h0020_0003);
      @(negedge clk);
    end
    chk("seed0_drain_hold", bus_a.stim, model_stim(32'h0, 15));
    chk("seed0_state_drain", bus_a.fsm_state, 2'd2);
    k = 0;
    while (bus_a.done !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("seed0_pass", bus_a.pass, 1'b1);

    // asynchronous reset mid-run, then a clean rerun
    bus_a.seed  = 32'h0000_ACE1;
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    flip_a[3] = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_cycle_cnt_before", bus_a.cycle_cnt, 16'd10);
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    flip_a = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(vecs[0], 100);

    // persistent mismatch on the 4-bit instance saturates the count
    flip_b = '1;
    bus_b.seed  = 32'h0000_0005;
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    k = 0;
    while (bus_b.done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
      if (k == 15) chk("sat_at_15", bus_b.mismatch_count, 4'hF);
    end
    flip_b = '0;
    chk("sat_compares", k, 16);
    chk("sat_mismatch", bus_b.mismatch_count, 4'hF);
    chk("sat_first_fail", bus_b.first_fail_cycle, 4'h0);
    chk("sat_pass", bus_b.pass, 1'b0);
    chk("sat_aborted", bus_b.aborted, 1'b0);
    chk("sat_fail_diff", bus_b.fail_diff, {Y_W{1'b1}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
